encoder8_3_pend_seq: RTL

Sequential 8-to-3 priority encoder. It is the return path paired with the 3-to-8 decoder. It captures rising edges on eight request lines D0..D7 into a pending register. It then presents one pending request at a time as a 3-bit code {A,B,C} with a valid/ack handshake, highest index first. It also provides an occupancy count and a sticky overflow flag for lost events.

---
 rtl/encoder8_3_pend_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/encoder8_3_pend_seq.sv
// Sequential 8-to-3 priority encoder: captures rising edges on D0..D7 into a
// pending register and hands them out one at a time, highest index first.
//
// state | meaning
// IDLE  | no code presented (valid=0); load as soon as anything is pending
// HOLD  | code on A,B,C is valid; held until ack, then reload or go idle
module encoder8_3_pend_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  input  logic       ack,
  input  logic       ovf_clr,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       ovf
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_nxt;
  logic [7:0] d_vec, d_q, rise, cap;
  logic [7:0] pending, pending_nxt, load_mask;
  logic [2:0] sel_idx, code_q;
  logic [3:0] cnt_nxt;
  logic       load, ovf_set;

  assign d_vec = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign rise  = d_vec & ~d_q;
  assign cap   = en ? rise : 8'h00;

  // Ascending scan, so the last hit is the highest pending index.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) sel_idx = i[2:0];
    end
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          if (|pending) load = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A fresh capture on the bit being loaded survives: set beats clear.
  always_comb begin
    load_mask   = load ? (8'h01 << sel_idx) : 8'h00;
    pending_nxt = (pending & ~load_mask) | cap;
    ovf_set     = |(cap & pending & ~load_mask);
    cnt_nxt     = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt = cnt_nxt + {3'b000, pending_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      d_q      <= 8'h00;
      pending  <= 8'h00;
      code_q   <= 3'd0;
      pend_cnt <= 4'd0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      d_q      <= d_vec;
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
      if (load) code_q <= sel_idx;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign valid     = (state_q == HOLD);
  assign {A, B, C} = code_q;

endmodule
